// File: rtl/defs.sv
// Shared types and constants for the generation sequencer.
package defs;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    STEP_START,
    STEP_WAIT,
    SWAP
  } gen_seq_state_t;

  // vblank edges per generation tick, indexed by speed select
  localparam int unsigned VBL_DIV [4] = '{1, 4, 16, 64};

endpackage

// File: rtl/gen_sequencer_if.sv
// Step-engine and field-loader handshake bundle seen by the sequencer.
interface gen_sequencer_if;
  logic i_is_loading;
  logic i_step_done;
  logic o_step_go;
  logic o_FCL_allowed;

  modport master (input i_is_loading, i_step_done, output o_step_go, o_FCL_allowed);
  modport slave  (output i_is_loading, i_step_done, input o_step_go, o_FCL_allowed);
endinterface

// File: rtl/vblank_tick_div.sv
// Counts vblank rising edges while enabled and emits a one-cycle tick every Nth edge.
module vblank_tick_div
  import defs::*;
#(
  parameter int DIV_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_vblank,
  input  logic [1:0] i_speed_sel,
  output logic       o_tick
);

  logic             vbl_q, vbl_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = i_vblank & ~vbl_q;

  always_comb begin
    vbl_d  = i_vblank;
    cnt_d  = cnt_q;
    o_tick = 1'b0;
    if (!i_en) begin
      cnt_d = '0;
    end else if (rise) begin
      // >= so a speed change to a smaller divisor mid-count ticks at once
      if (cnt_q >= DIV_W'(VBL_DIV[i_speed_sel] - 1)) begin
        o_tick = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vbl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vbl_q <= vbl_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gen_sequencer.sv
// Run/pause/step sequencer: paces generation steps off vblank and flips the display buffer.
module gen_sequencer
  import defs::*;
#(
  parameter int GEN_CNT_W = 16,
  parameter int DIV_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cmd_run,
  input  logic                 i_cmd_step,
  input  logic [1:0]           i_speed_sel,
  input  logic                 i_vblank,
  gen_sequencer_if.master      bus,
  output logic                 o_buf_sel,
  output logic                 o_running,
  output logic [GEN_CNT_W-1:0] o_gen_cnt
);

  gen_seq_state_t       state_q, state_d;
  logic                 run_q, run_d;
  logic                 pend_step_q, pend_step_d;
  logic                 pend_tog_q, pend_tog_d;
  logic                 buf_q, buf_d;
  logic [GEN_CNT_W-1:0] cnt_q, cnt_d;
  logic                 run_prev_q, step_prev_q, load_prev_q;
  logic                 run_edge, step_edge, load_fall, tick, run_nxt;

  assign run_edge  = i_cmd_run & ~run_prev_q;
  assign step_edge = i_cmd_step & ~step_prev_q;
  assign load_fall = load_prev_q & ~bus.i_is_loading;

  vblank_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (state_q == WAIT_TICK),
    .i_vblank    (i_vblank),
    .i_speed_sel (i_speed_sel),
    .o_tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    pend_step_d = pend_step_q;
    pend_tog_d  = pend_tog_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    run_nxt     = run_q;
    unique case (state_q)
      IDLE: begin
        if (run_edge) begin
          run_d   = 1'b1;
          state_d = WAIT_TICK;
        end else if (step_edge && !bus.i_is_loading) begin
          state_d = STEP_START;
        end
      end
      WAIT_TICK: begin
        if (run_edge) begin
          run_d       = 1'b0;
          pend_step_d = 1'b0;
          state_d     = IDLE;
        end else if ((tick || pend_step_q) && !bus.i_is_loading) begin
          pend_step_d = 1'b0;
          state_d     = STEP_START;
        end else if (tick) begin
          pend_step_d = 1'b1;
        end
      end
      STEP_START: begin
        if (run_edge) pend_tog_d = 1'b1;
        state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (run_edge) pend_tog_d = 1'b1;
        if (bus.i_step_done) state_d = SWAP;
      end
      SWAP: begin
        run_nxt    = run_q ^ (pend_tog_q | run_edge);
        run_d      = run_nxt;
        pend_tog_d = 1'b0;
        buf_d      = ~buf_q;
        cnt_d      = cnt_q + 1'b1;
        state_d    = run_nxt ? WAIT_TICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a finished field load restarts the generation history, even over a swap
    if (load_fall) begin
      buf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      pend_step_q <= 1'b0;
      pend_tog_q  <= 1'b0;
      buf_q       <= 1'b0;
      cnt_q       <= '0;
      run_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      pend_step_q <= pend_step_d;
      pend_tog_q  <= pend_tog_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      run_prev_q  <= i_cmd_run;
      step_prev_q <= i_cmd_step;
      load_prev_q <= bus.i_is_loading;
    end
  end

  assign bus.o_step_go     = (state_q == STEP_START);
  assign bus.o_FCL_allowed = (state_q == IDLE) || (state_q == WAIT_TICK && !pend_step_q);
  assign o_buf_sel         = buf_q;
  assign o_running         = run_q;
  assign o_gen_cnt         = cnt_q;

endmodule

// File: tb/tb_gen_sequencer.sv
// Randomized and directed checks of gen_sequencer against a cycle-level behavioural model.
module tb_gen_sequencer;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cmd_run = 1'b0, i_cmd_step = 1'b0, i_vblank = 1'b0;
  logic [1:0]    i_speed_sel = 2'd0;
  logic          o_buf_sel, o_running;
  logic [CW-1:0] o_gen_cnt;

  gen_sequencer_if bus ();

  gen_sequencer #(.GEN_CNT_W(CW), .DIV_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_run   (i_cmd_run),
    .i_cmd_step  (i_cmd_step),
    .i_speed_sel (i_speed_sel),
    .i_vblank    (i_vblank),
    .bus         (bus.master),
    .o_buf_sel   (o_buf_sel),
    .o_running   (o_running),
    .o_gen_cnt   (o_gen_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = not stepping (paused when !m_run, waiting for a tick when m_run),
  //        1 = go pulse, 2 = engine busy, 3 = buffer swap
  int m_phase = 0, m_vb = 0, m_cnt = 0;
  bit m_run = 0, m_pend = 0, m_tog = 0, m_buf = 0;
  bit p_run = 0, p_step = 0, p_vb = 0, p_load = 0;

  task automatic model_step();
    bit re, se, ve, lf, tick, nb;
    int div, nc;
    if (!rst_n) begin
      m_phase = 0; m_vb = 0; m_cnt = 0;
      m_run = 0; m_pend = 0; m_tog = 0; m_buf = 0;
      p_run = 0; p_step = 0; p_vb = 0; p_load = 0;
      return;
    end
    re  = i_cmd_run && !p_run;
    se  = i_cmd_step && !p_step;
    ve  = i_vblank && !p_vb;
    lf  = p_load && !bus.i_is_loading;
    div = 1 << (2 * i_speed_sel);
    nb  = m_buf;
    nc  = m_cnt;
    case (m_phase)
      0: begin
        if (!m_run) begin
          if (re) m_run = 1;
          else if (se && !bus.i_is_loading) m_phase = 1;
        end else begin
          tick = 0;
          if (ve) begin
            if (m_vb + 1 >= div) begin tick = 1; m_vb = 0; end
            else m_vb++;
          end
          if (re) begin
            m_run = 0; m_pend = 0; m_vb = 0;
          end else if ((tick || m_pend) && !bus.i_is_loading) begin
            m_phase = 1; m_pend = 0; m_vb = 0;
          end else if (tick) begin
            m_pend = 1;
          end
        end
      end
      1: begin
        if (re) m_tog = 1;
        m_phase = 2;
      end
      2: begin
        if (re) m_tog = 1;
        if (bus.i_step_done) m_phase = 3;
      end
      default: begin
        if (m_tog || re) m_run = !m_run;
        m_tog   = 0;
        nb      = !m_buf;
        nc      = (m_cnt + 1) % (1 << CW);
        m_phase = 0;
      end
    endcase
    if (lf) begin nb = 0; nc = 0; end
    m_buf  = nb;
    m_cnt  = nc;
    p_run  = i_cmd_run;
    p_step = i_cmd_step;
    p_vb   = i_vblank;
    p_load = bus.i_is_loading;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int go_cnt = 0;
  initial forever begin
    @(negedge clk);
    chk("m_step_go", bus.o_step_go, (m_phase == 1));
    chk("m_fcl",     bus.o_FCL_allowed, (m_phase == 0) && (!m_run || !m_pend));
    chk("m_running", o_running, m_run);
    chk("m_buf_sel", o_buf_sel, m_buf);
    chk("m_gen_cnt", o_gen_cnt, m_cnt);
    if (bus.o_step_go) go_cnt++;
  end

  // ---------------- step engine responder ----------------
  int resp_wait = -1, resp_dly = 5;
  bit resp_en = 0, spur_en = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (resp_en) begin
      bus.i_step_done = 1'b0;
      if (resp_wait == 0) begin
        bus.i_step_done = 1'b1;
        resp_wait = -1;
      end else if (resp_wait > 0) begin
        resp_wait--;
      end
      if (spur_en && $urandom_range(19) == 0) bus.i_step_done = 1'b1;
      if (bus.o_step_go) resp_wait = spur_en ? int'($urandom_range(4)) : resp_dly;
    end else begin
      resp_wait = -1;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    i_cmd_run = 1'b0; i_cmd_step = 1'b0; i_vblank = 1'b0;
    bus.i_is_loading = 1'b0;
    if (!resp_en) bus.i_step_done = 1'b0;
    cyc(2);
    chk("rst_step_go", bus.o_step_go, 0);
    chk("rst_fcl",     bus.o_FCL_allowed, 1);
    chk("rst_running", o_running, 0);
    chk("rst_buf_sel", o_buf_sel, 0);
    chk("rst_gen_cnt", o_gen_cnt, 0);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic run_edge();
    i_cmd_run = 1'b1; cyc(1);
    i_cmd_run = 1'b0; cyc(1);
  endtask

  initial begin
    int base;
    bit ok;
    bus.i_is_loading = 1'b0;
    bus.i_step_done  = 1'b0;

    // single step from pause
    do_reset();
    i_cmd_step = 1'b1; cyc(1);
    chk("s1_step_go", bus.o_step_go, 1);
    i_cmd_step = 1'b0; cyc(1);
    chk("s1_go_once", bus.o_step_go, 0);
    bus.i_step_done = 1'b1; cyc(1);
    bus.i_step_done = 1'b0; cyc(1);
    chk("s1_buf", o_buf_sel, 1);
    chk("s1_cnt", o_gen_cnt, 1);
    chk("s1_idle_fcl", bus.o_FCL_allowed, 1);
    chk("s1_running", o_running, 0);

    // run, divide by 4, eight vblanks
    do_reset();
    resp_en = 1; resp_dly = 5; i_speed_sel = 2'd1;
    base = go_cnt;
    run_edge();
    for (int v = 0; v < 8; v++) begin
      i_vblank = 1'b1; cyc(3);
      i_vblank = 1'b0; cyc(17);
    end
    cyc(20);
    chk("s2_pulses", go_cnt - base, 2);
    chk("s2_cnt", o_gen_cnt, 2);
    chk("s2_buf", o_buf_sel, 0);
    chk("s2_running", o_running, 1);
    run_edge();

    // tick held off by a load, load completion clears history
    do_reset();
    resp_dly = 2; i_speed_sel = 2'd0;
    run_edge();
    i_vblank = 1'b1; cyc(1); i_vblank = 1'b0; cyc(10);
    chk("s3_first_cnt", o_gen_cnt, 1);
    bus.i_is_loading = 1'b1; cyc(1);
    i_vblank = 1'b1; cyc(1); i_vblank = 1'b0;
    chk("s3_pend_fcl", bus.o_FCL_allowed, 0);
    chk("s3_pend_go", bus.o_step_go, 0);
    cyc(4);
    chk("s3_hold_fcl", bus.o_FCL_allowed, 0);
    chk("s3_hold_go", bus.o_step_go, 0);
    bus.i_is_loading = 1'b0; cyc(1);
    chk("s3_go", bus.o_step_go, 1);
    chk("s3_cnt_clr", o_gen_cnt, 0);
    cyc(10);
    chk("s3_cnt_after", o_gen_cnt, 1);
    chk("s3_buf_after", o_buf_sel, 1);

    // pause requested while the engine is busy
    do_reset();
    resp_dly = 4;
    run_edge();
    i_vblank = 1'b1; cyc(1); i_vblank = 1'b0; cyc(1);
    i_cmd_run = 1'b1; cyc(1); i_cmd_run = 1'b0;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      cyc(1);
      if (!o_running) ok = 1;
    end
    chk("s4_paused", ok, 1);
    chk("s4_fcl", bus.o_FCL_allowed, 1);
    chk("s4_cnt", o_gen_cnt, 1);
    base = go_cnt;
    for (int v = 0; v < 3; v++) begin
      i_vblank = 1'b1; cyc(2); i_vblank = 1'b0; cyc(2);
    end
    chk("s4_no_go", go_cnt - base, 0);

    // counter wrap, then reset in the middle of a step
    do_reset();
    resp_dly = 0;
    for (int s = 0; s < (1 << CW); s++) begin
      i_cmd_step = 1'b1; cyc(1);
      i_cmd_step = 1'b0; cyc(5);
      if (s == (1 << CW) - 2) chk("s5_cnt_max", o_gen_cnt, (1 << CW) - 1);
    end
    chk("s5_wrap", o_gen_cnt, 0);
    chk("s5_wrap_buf", o_buf_sel, 0);
    i_cmd_step = 1'b1; cyc(1); i_cmd_step = 1'b0; cyc(5);
    chk("s5_cnt_one", o_gen_cnt, 1);
    resp_en = 0; bus.i_step_done = 1'b0;
    i_cmd_step = 1'b1; cyc(1); i_cmd_step = 1'b0; cyc(1);
    do_reset();
    cyc(3);
    chk("s5_no_swap", o_buf_sel, 0);

    // random traffic against the model
    resp_en = 1; spur_en = 1;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      i_cmd_run  = ($urandom_range(59) == 0);
      i_cmd_step = ($urandom_range(9) == 0);
      i_vblank   = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) bus.i_is_loading = ~bus.i_is_loading;
      if ($urandom_range(199) == 0) i_speed_sel = 2'($urandom_range(3));
      rst_n = ($urandom_range(799) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
